// File: rtl/sd_sector_buffer.sv
// -----------------------------------------------------------------------------
// sd_sector_buffer
//
// One-sector (512 byte) staging buffer between a host and an SD card
// controller. The host fills or drains the buffer through its own port and
// asks for a single-sector READ (card -> buffer) or WRITE (buffer -> card).
// A small FSM hands the command to the card controller, counts the bytes
// moved, watches for overrun/short blocks and aborts after TIMEOUT_CYCLES.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   host_req/host_op/host_lba       start a transfer (op 0 READ, 1 WRITE)
//   host_busy/host_done/host_err    transfer status, done/err are 1-cycle pulses
//   buf_addr/buf_we/buf_wdata       host buffer port (writes ignored while busy)
//   buf_rdata                       host read data, 1-cycle latency
//   sd_execute/sd_op_code           command to the card controller
//   sd_block_address                latched sector address
//   sd_busy/sd_block_done           card controller status
//   sd_byte_strobe                  one pulse per byte moved on the card side
//   sd_incoming_byte                card read data
//   sd_outgoing_byte                card write data, mem[ptr]
//
// States
//   state  | meaning
//   IDLE   | waiting for host_req; host owns the buffer
//   ISSUE  | sd_execute high until the card reports busy
//   XFER   | moving bytes on sd_byte_strobe, waiting for sd_block_done
//   DONE   | one-cycle host_done pulse
//   ERR    | one-cycle host_err pulse (short block, overrun or timeout)
// -----------------------------------------------------------------------------
module sd_sector_buffer #(
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_req,
    input  logic        host_op,
    input  logic [31:0] host_lba,
    output logic        host_busy,
    output logic        host_done,
    output logic        host_err,
    input  logic [8:0]  buf_addr,
    input  logic        buf_we,
    input  logic [7:0]  buf_wdata,
    output logic [7:0]  buf_rdata,
    output logic        sd_execute,
    output logic        sd_op_code,
    output logic [31:0] sd_block_address,
    input  logic        sd_busy,
    input  logic        sd_byte_strobe,
    input  logic [7:0]  sd_incoming_byte,
    output logic [7:0]  sd_outgoing_byte,
    input  logic        sd_block_done
);

    localparam int unsigned     TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]      FULL     = 10'd512;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_XFER,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic               op_q, op_d;
    logic [31:0]        lba_q, lba_d;
    logic [8:0]         ptr_q, ptr_d;
    logic [9:0]         cnt_q, cnt_d;
    logic               ovr_q, ovr_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic [7:0]         mem [0:511];
    logic [7:0]         host_rd_q;
    logic [7:0]         card_rd_q;
    logic               card_we;
    logic               host_we;
    logic [8:0]         card_addr;
    logic               take_byte;
    logic               tmo_hit;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            lba_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            lba_q   <= lba_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        lba_d     = lba_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ovr_d     = ovr_q;
        tmo_d     = tmo_q;
        card_we   = 1'b0;
        tmo_hit   = (tmo_q == '0);
        take_byte = sd_byte_strobe && (cnt_q != FULL);

        case (state_q)
            S_IDLE: begin
                if (host_req) begin
                    op_d    = host_op;
                    lba_d   = host_lba;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    ovr_d   = 1'b0;
                    tmo_d   = TMO_LOAD;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (tmo_hit) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                    if (sd_busy) begin
                        state_d = S_XFER;
                    end
                end
            end
            S_XFER: begin
                if (!tmo_hit) begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
                if (take_byte) begin
                    ptr_d   = ptr_q + 9'd1;
                    cnt_d   = cnt_q + 10'd1;
                    card_we = !op_q;
                end else if (sd_byte_strobe) begin
                    // buffer already full: drop the byte, remember the overrun
                    ovr_d = 1'b1;
                end
                // a strobe in the block_done cycle is already folded into cnt_d/ovr_d
                if (sd_block_done) begin
                    state_d = (cnt_d == FULL && !ovr_d) ? S_DONE : S_ERR;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        host_busy  = 1'b0;
        host_done  = 1'b0;
        host_err   = 1'b0;
        sd_execute = 1'b0;
        case (state_q)
            S_IDLE:  host_busy = 1'b0;
            S_ISSUE: begin
                host_busy  = 1'b1;
                sd_execute = 1'b1;
            end
            S_XFER:  host_busy = 1'b1;
            S_DONE: begin
                host_busy = 1'b1;
                host_done = 1'b1;
            end
            S_ERR: begin
                host_busy = 1'b1;
                host_err  = 1'b1;
            end
            default: host_busy = 1'b0;
        endcase
    end

    assign sd_op_code       = op_q;
    assign sd_block_address = lba_q;

    // ------------------------------------------------------------------
    // Sector storage: one host port, one card port. Host writes are only
    // possible in IDLE and card writes only in XFER, so they never collide.
    // The card port reads ahead at ptr_d so sd_outgoing_byte tracks the new
    // pointer in the same cycle the pointer moves.
    // ------------------------------------------------------------------
    assign host_we   = buf_we && !host_busy;
    assign card_addr = card_we ? ptr_q : ptr_d;

    always_ff @(posedge clk) begin
        if (card_we) begin
            mem[card_addr] <= sd_incoming_byte;
        end else begin
            card_rd_q <= mem[card_addr];
        end
        if (host_we) begin
            mem[buf_addr] <= buf_wdata;
        end
        host_rd_q <= mem[buf_addr];
    end

    assign buf_rdata        = host_rd_q;
    assign sd_outgoing_byte = card_rd_q;

endmodule

// File: tb/tb_sd_sector_buffer.sv
// -----------------------------------------------------------------------------
// tb_sd_sector_buffer
//
// Directed bench for sd_sector_buffer. A transaction-level model (sector
// array, busy/done/err expectations, byte pointer) is advanced by the
// stimulus tasks; one negedge process compares the DUT against it every
// cycle. A second instance with TIMEOUT_CYCLES=64 covers the abort path.
// -----------------------------------------------------------------------------
module tb_sd_sector_buffer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        host_req, host_op;
    logic [31:0] host_lba;
    logic        host_busy, host_done, host_err;
    logic [8:0]  buf_addr;
    logic        buf_we;
    logic [7:0]  buf_wdata, buf_rdata;
    logic        sd_execute, sd_op_code;
    logic [31:0] sd_block_address;
    logic        sd_busy, sd_byte_strobe, sd_block_done;
    logic [7:0]  sd_incoming_byte, sd_outgoing_byte;

    logic        host_req_t, sd_busy_t;
    logic        host_busy_t, host_done_t, host_err_t;
    logic [7:0]  buf_rdata_t, sd_outgoing_byte_t;
    logic        sd_execute_t, sd_op_code_t;
    logic [31:0] sd_block_address_t;

    sd_sector_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_op(host_op), .host_lba(host_lba),
        .host_busy(host_busy), .host_done(host_done), .host_err(host_err),
        .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
        .sd_execute(sd_execute), .sd_op_code(sd_op_code), .sd_block_address(sd_block_address),
        .sd_busy(sd_busy), .sd_byte_strobe(sd_byte_strobe), .sd_incoming_byte(sd_incoming_byte),
        .sd_outgoing_byte(sd_outgoing_byte), .sd_block_done(sd_block_done)
    );

    sd_sector_buffer #(.TIMEOUT_CYCLES(64)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req_t), .host_op(host_op), .host_lba(host_lba),
        .host_busy(host_busy_t), .host_done(host_done_t), .host_err(host_err_t),
        .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata_t),
        .sd_execute(sd_execute_t), .sd_op_code(sd_op_code_t), .sd_block_address(sd_block_address_t),
        .sd_busy(sd_busy_t), .sd_byte_strobe(sd_byte_strobe), .sd_incoming_byte(sd_incoming_byte),
        .sd_outgoing_byte(sd_outgoing_byte_t), .sd_block_done(sd_block_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_mem [512];
    bit          m_v   [512];
    bit          m_busy, m_done, m_err, m_exec, m_op;
    logic [31:0] m_lba;
    int          m_ptr, m_cnt;
    bit          chk_en = 1'b0;

    logic [7:0]  exp_rd;
    bit          exp_rd_v = 1'b0;
    int          done_cnt = 0;
    int          err_cnt  = 0;

    // host read is read-before-write: capture the model at the edge
    always @(posedge clk) begin
        exp_rd   = m_mem[buf_addr];
        exp_rd_v = m_v[buf_addr];
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("host_busy", host_busy, m_busy);
            check("host_done", host_done, m_done);
            check("host_err", host_err, m_err);
            check("sd_execute", sd_execute, m_exec);
            check("sd_op_code", sd_op_code, m_op);
            check("sd_block_address", sd_block_address, m_lba);
            if (exp_rd_v) check("buf_rdata", buf_rdata, exp_rd);
            if (m_busy && m_op && !m_done && !m_err && m_cnt < 512 && m_v[m_ptr])
                check("sd_outgoing_byte", sd_outgoing_byte, m_mem[m_ptr]);
            if (host_done) done_cnt++;
            if (host_err)  err_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_xfer(input bit op, input logic [31:0] lba, input int nstb,
                            input bit done_with_last, input int rst_at, input logic [7:0] key);
        bit last, ok;
        host_req = 1'b1; host_op = op; host_lba = lba;
        @(posedge clk); #1;
        host_req = 1'b0;
        m_busy = 1'b1; m_exec = 1'b1; m_op = op; m_lba = lba; m_ptr = 0; m_cnt = 0;
        // all of these must be ignored while the transfer is open
        host_req = 1'b1; host_op = !op; host_lba = ~lba;
        buf_we = 1'b1; buf_addr = 9'd5; buf_wdata = 8'h00;
        sd_block_done = 1'b1;
        @(posedge clk); #1;
        host_req = 1'b0; buf_we = 1'b0; sd_block_done = 1'b0;
        sd_busy = 1'b1;
        @(posedge clk); #1;
        m_exec = 1'b0;
        for (int i = 0; i < nstb; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                sd_busy = 1'b0;
                m_busy = 1'b0; m_exec = 1'b0; m_op = 1'b0; m_lba = '0;
                m_done = 1'b0; m_err = 1'b0;
                #1;
                check("rst_busy", host_busy, 1'b0);
                check("rst_exec", sd_execute, 1'b0);
                check("rst_done", host_done, 1'b0);
                check("rst_err", host_err, 1'b0);
                check("rst_opcode", sd_op_code, 1'b0);
                check("rst_lba", sd_block_address, 32'h0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            last = (i == nstb - 1);
            sd_byte_strobe   = 1'b1;
            sd_incoming_byte = (i < 512) ? (8'(i) ^ key) : 8'hEE;
            if (last && done_with_last) sd_block_done = 1'b1;
            @(posedge clk); #1;
            sd_byte_strobe = 1'b0; sd_block_done = 1'b0;
            if (m_cnt < 512) begin
                if (!op) begin
                    m_mem[m_ptr] = 8'(i) ^ key;
                    m_v[m_ptr]   = 1'b1;
                end
                m_ptr++;
            end
            m_cnt++;
            if (!last && (i % 5 == 2)) begin
                @(posedge clk); #1;
            end
        end
        if (!done_with_last) begin
            sd_block_done = 1'b1;
            @(posedge clk); #1;
            sd_block_done = 1'b0;
        end
        ok = (m_cnt == 512);
        m_done = ok; m_err = !ok;
        @(posedge clk); #1;
        m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0;
        sd_busy = 1'b0;
    endtask

    task automatic read_at(input logic [8:0] a);
        buf_addr = a;
        @(posedge clk); #1;
    endtask

    int first_err;
    bit exec_63, exec_64;

    initial begin
        rst_n = 1'b0;
        host_req = 1'b0; host_op = 1'b0; host_lba = '0;
        buf_addr = '0; buf_we = 1'b0; buf_wdata = '0;
        sd_busy = 1'b0; sd_byte_strobe = 1'b0; sd_incoming_byte = '0; sd_block_done = 1'b0;
        host_req_t = 1'b0; sd_busy_t = 1'b0;
        m_busy = 0; m_done = 0; m_err = 0; m_exec = 0; m_op = 0; m_lba = '0; m_ptr = 0; m_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", host_busy, 1'b0);
        check("reset_exec", sd_execute, 1'b0);
        check("reset_lba", sd_block_address, 32'h0);
        check("reset_opcode", sd_op_code, 1'b0);
        check("reset_pulses", {host_done, host_err}, 2'b00);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // stray block_done in IDLE
        sd_block_done = 1'b1;
        @(posedge clk); #1;
        sd_block_done = 1'b0;
        @(posedge clk); #1;

        // READ, block_done together with the last strobe
        run_xfer(1'b0, 32'h10, 512, 1'b1, -1, 8'h00);
        check("read_done_cnt", done_cnt, 1);
        check("read_err_cnt", err_cnt, 0);
        read_at(9'h1FF);
        check("read_mem_1ff", buf_rdata, 8'hFF);

        // host fill ~i, then WRITE
        for (int i = 0; i < 512; i++) begin
            buf_we = 1'b1; buf_addr = 9'(i); buf_wdata = ~8'(i);
            @(posedge clk); #1;
            m_mem[i] = ~8'(i);
            m_v[i]   = 1'b1;
        end
        buf_we = 1'b0;
        run_xfer(1'b1, 32'hCAFE_0123, 512, 1'b0, -1, 8'h00);
        check("write_done_cnt", done_cnt, 2);
        check("write_lba", sd_block_address, 32'hCAFE_0123);
        check("write_opcode", sd_op_code, 1'b1);
        read_at(9'd5);
        check("write_mem5_kept", buf_rdata, 8'hFA);

        // short block: 511 strobes
        run_xfer(1'b0, 32'h20, 511, 1'b0, -1, 8'hA5);
        check("short_err_cnt", err_cnt, 1);
        check("short_done_cnt", done_cnt, 2);
        check("short_idle", host_busy, 1'b0);

        // overrun: 514 strobes, last two must not land anywhere
        run_xfer(1'b0, 32'h30, 514, 1'b0, -1, 8'h3C);
        check("ovr_err_cnt", err_cnt, 2);
        for (int a = 0; a < 512; a++) read_at(9'(a));
        read_at(9'd0);
        check("ovr_mem0", buf_rdata, 8'h3C);
        read_at(9'h1FF);
        check("ovr_mem1ff", buf_rdata, 8'hC3);

        // reset at byte 200, then a clean read
        run_xfer(1'b0, 32'h40, 512, 1'b0, 200, 8'h77);
        check("rst_no_pulse", done_cnt + err_cnt, 4);
        run_xfer(1'b0, 32'h50, 512, 1'b1, -1, 8'h11);
        check("after_rst_done_cnt", done_cnt, 3);
        read_at(9'd2);
        check("after_rst_mem2", buf_rdata, 8'h13);

        // timeout on the 64-cycle instance, card never goes busy
        host_req_t = 1'b1; host_op = 1'b0; host_lba = 32'h99;
        @(posedge clk); #1;
        host_req_t = 1'b0;
        first_err = -1; exec_63 = 1'b0; exec_64 = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k == 63) exec_63 = sd_execute_t;
            if (host_err_t && first_err < 0) begin
                first_err = k;
                exec_64   = sd_execute_t;
            end
            if (host_done_t) check("to_no_done", host_done_t, 1'b0);
            if (first_err >= 0 && k > first_err) break;
        end
        check("to_err_cycle", first_err, 64);
        check("to_exec_before", exec_63, 1'b1);
        check("to_exec_dropped", exec_64, 1'b0);
        check("to_idle_after", host_busy_t, 1'b0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_sector_buffer.md
SD_SECTOR_BUFFER -- requirements
Module: sd_sector_buffer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1048576; cycles allowed from command issue to block-done before abort.
REQ-002 clk  in  1  master clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-004 host_req  in  1  single-cycle pulse; start one sector transfer.
REQ-005 host_op  in  1  0 = READ (card to buffer), 1 = WRITE (buffer to card); sampled with host_req.
REQ-006 host_lba  in  32  sector address; sampled with host_req.
REQ-007 host_busy  out  1  high from accepted host_req until the DONE/ERR cycle.
REQ-008 host_done  out  1  one-cycle pulse on successful completion.
REQ-009 host_err  out  1  one-cycle pulse on failed transfer; shares the cycle host_done would use.
REQ-010 buf_addr  in  9  host buffer address 0..511.
REQ-011 buf_we  in  1  host buffer write enable.
REQ-012 buf_wdata  in  8  host buffer write data.
REQ-013 buf_rdata  out  8  host buffer read data; mem[buf_addr] registered, 1-cycle latency.
REQ-014 sd_execute  out  1  execute request to the card controller.
REQ-015 sd_op_code  out  1  op to the card controller; 0 READ, 1 WRITE.
REQ-016 sd_block_address  out  32  latched host_lba.
REQ-017 sd_busy  in  1  card controller busy.
REQ-018 sd_byte_strobe  in  1  one-cycle pulse per data byte moved (read: sd_incoming_byte valid; write: sd_outgoing_byte consumed).
REQ-019 sd_incoming_byte  in  8  read data byte.
REQ-020 sd_outgoing_byte  out  8  write data byte = mem[ptr]; stable until the next strobe.
REQ-021 sd_block_done  in  1  one-cycle pulse; card operation finished.

Function
REQ-022 Storage is a 512x8 array; the card side and the host side each have one port.
REQ-023 FSM states: IDLE, ISSUE, XFER, DONE, ERR.
REQ-024 IDLE: on host_req, latch host_op and host_lba, clear ptr and count, clear timeout, go to ISSUE; host_req in any other state is ignored.
REQ-025 ISSUE: drive sd_execute=1 until sd_busy is sampled high, then drive sd_execute=0 and go to XFER.
REQ-026 XFER: each sd_byte_strobe in a READ writes sd_incoming_byte to mem[ptr] and increments ptr; in a WRITE it increments ptr only.
REQ-027 ptr is 9 bits; count is 10 bits and saturates at 512; strobes received after count=512 cause no write, no wrap, and set an overrun flag.
REQ-028 sd_outgoing_byte reflects mem[ptr] no later than 1 cycle after ptr changes; in ISSUE it equals mem[0].
REQ-029 On sd_block_done in XFER: go to DONE if count=512 and there is no overrun, otherwise go to ERR.
REQ-030 If sd_block_done and sd_byte_strobe arrive in the same cycle, the byte is processed first and counts toward the 512.
REQ-031 The timeout counter runs in ISSUE and XFER; at TIMEOUT_CYCLES-1 the FSM goes to ERR and sd_execute drops.
REQ-032 DONE pulses host_done and ERR pulses host_err, each for exactly 1 cycle, then the FSM returns to IDLE; host_busy is low in IDLE only.
REQ-033 Host buffer writes are ignored while host_busy=1; host reads are allowed at all times.
REQ-034 sd_block_done in IDLE or ISSUE is ignored.

Reset
REQ-035 On rst_n low, immediately: state=IDLE; host_busy, host_done, host_err and sd_execute = 0; sd_op_code=0; sd_block_address=0; ptr, count, timeout and overrun = 0.
REQ-036 Reset does not clear the buffer contents; their value after power-up is undefined.
REQ-037 Reset asserted mid-transfer abandons the transfer with no done/err pulse; after release the block accepts a new host_req.

Verification
REQ-038 Read: host_req op=0 lba=0x10; model card supplies 512 strobes with bytes i[7:0] then block_done -> host_done pulse once; buf_rdata at addr 0x1FF = 0xFF.
REQ-039 Write: host fills mem[i]=~i, then host_req op=1 -> sd_outgoing_byte sequence 0xFF,0xFE,... across 512 strobes; host_done pulses; sd_block_address=lba.
REQ-040 Short block: 511 strobes then block_done -> host_err pulse, no host_done, return to IDLE.
REQ-041 Overrun: 514 strobes then block_done -> mem[0..511] intact, host_err pulse.
REQ-042 Timeout: TIMEOUT_CYCLES=64 and sd_busy never rises -> host_err at cycle 64 after ISSUE entry; sd_execute=0.
REQ-043 Reset mid-XFER at byte 200 -> all outputs at reset values; a subsequent read completes normally.
